// File: rtl/tick_sched.sv
// tick_sched: NCH periodic base-tick timers with round-robin arbitration onto one valid/ready event port
module tick_sched #(
  parameter int NCH  = 4,
  parameter int CHW  = 2,
  parameter int PERW = 16
) (
  input  logic            mclk,
  input  logic            reset,
  input  logic            tick_in,
  input  logic            cfg_we,
  input  logic [CHW-1:0]  cfg_ch,
  input  logic [PERW-1:0] cfg_period,
  input  logic            cfg_en,
  output logic            ev_valid,
  output logic [CHW-1:0]  ev_ch,
  input  logic            ev_ready,
  output logic [NCH-1:0]  overrun
);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t          state;
  logic [NCH-1:0]  en, pending, wr, expire, hs_ch;
  logic [PERW-1:0] period [NCH];
  logic [PERW-1:0] cnt [NCH];
  logic [CHW-1:0]  last_grant, pick;
  logic            found, hs;
  assign hs = state == OFFER && ev_valid && ev_ready;
  // A write to a channel shadows its tick that cycle, so it never expires while being written.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      wr[i]     = cfg_we && cfg_ch == CHW'(i);
      expire[i] = tick_in && en[i] && !wr[i] && cnt[i] == PERW'(1);
      hs_ch[i]  = hs && ev_ch == CHW'(i);
    end
  end
  always_comb begin
    found = 1'b0;
    pick  = last_grant;
    for (int k = 1; k <= NCH; k++) begin
      if (!found && pending[(int'(last_grant) + k) % NCH]) begin
        found = 1'b1;
        pick  = CHW'((int'(last_grant) + k) % NCH);
      end
    end
  end
  always_ff @(posedge mclk) begin
    if (reset) begin
      state      <= IDLE;
      ev_valid   <= 1'b0;
      ev_ch      <= '0;
      last_grant <= CHW'(NCH - 1);
      en         <= '0;
      pending    <= '0;
      overrun    <= '0;
      for (int i = 0; i < NCH; i++) begin
        period[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr[i]) begin
          period[i]  <= cfg_period;
          cnt[i]     <= cfg_period;
          en[i]      <= cfg_en && cfg_period != '0;
          pending[i] <= 1'b0;
          overrun[i] <= 1'b0;
        end else begin
          if (tick_in && en[i]) cnt[i] <= expire[i] ? period[i] : cnt[i] - PERW'(1);
          pending[i] <= expire[i] | (pending[i] & ~hs_ch[i]);
          if (expire[i] && pending[i] && !hs_ch[i]) overrun[i] <= 1'b1;
        end
      end
      if (state == IDLE) begin
        if (found) begin
          ev_ch    <= pick;
          ev_valid <= 1'b1;
          state    <= OFFER;
        end
      end else if (ev_ready) begin
        ev_valid   <= 1'b0;
        last_grant <= ev_ch;
        state      <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_tick_sched.sv
// tb_tick_sched: directed scoreboard bench; NCH=5 leaves codes 5..7 free for out-of-range config writes
module tb_tick_sched;
  localparam int NCH = 5, CHW = 3, PERW = 16;
  logic            mclk = 0, reset = 1, tick_in = 0, cfg_we = 0, cfg_en = 0, ev_ready = 0;
  logic [CHW-1:0]  cfg_ch = '0;
  logic [PERW-1:0] cfg_period = '0;
  logic            ev_valid;
  logic [CHW-1:0]  ev_ch;
  logic [NCH-1:0]  overrun;
  int              n_checks = 0, n_fail = 0;
  logic [CHW-1:0]  sb [$];

  tick_sched #(.NCH(NCH), .CHW(CHW), .PERW(PERW)) dut (
    .mclk(mclk), .reset(reset), .tick_in(tick_in), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_en(cfg_en), .ev_valid(ev_valid), .ev_ch(ev_ch),
    .ev_ready(ev_ready), .overrun(overrun)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshakes are judged on the negedge before the accepting posedge.
  always @(negedge mclk) begin
    if (!reset && ev_valid && ev_ready) begin
      if (sb.size() == 0) chk("unexpected_event", {29'd0, ev_ch}, 32'hffff_ffff);
      else chk("event_ch", {29'd0, ev_ch}, {29'd0, sb.pop_front()});
    end
  end

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic tick();
    tick_in = 1;
    step();
    tick_in = 0;
  endtask

  task automatic cfg(input logic [CHW-1:0] ch, input logic [PERW-1:0] per, input logic en);
    cfg_we = 1; cfg_ch = ch; cfg_period = per; cfg_en = en;
    step();
    cfg_we = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0 && !ev_valid) break;
      step();
    end
    chk(tag, {31'd0, sb.size() == 0 && !ev_valid}, 32'd1);
  endtask

  initial begin
    step();
    reset = 0;
    chk("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
    chk("rst_ev_ch", {29'd0, ev_ch}, 32'd0);
    chk("rst_overrun", {27'd0, overrun}, 32'd0);

    // 1: ch0 period 3, events on ticks 3, 6, 9
    ev_ready = 1;
    cfg(0, 3, 1);
    for (int t = 1; t <= 9; t++) begin
      if (t % 3 == 0) sb.push_back(0);
      tick();
      if (t == 3) begin
        chk("t1_lat_n", {31'd0, ev_valid}, 32'd0);
        step();
        chk("t1_lat_n1", {31'd0, ev_valid}, 32'd1);
        repeat (8) step();
      end else repeat (9) step();
    end
    wait_idle("t1_drain");
    chk("t1_overrun", {27'd0, overrun}, 32'd0);

    // 2: ch0..ch3 period 1, two rounds in order 0..3
    do_reset();
    for (int c = 0; c < 4; c++) cfg(CHW'(c), 1, 1);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) sb.push_back(CHW'(c));
      tick();
      wait_idle(r == 0 ? "t2_round0" : "t2_round1");
    end
    chk("t2_overrun", {27'd0, overrun}, 32'd0);

    // 3: ch2 period 2 with consumer stalled
    do_reset();
    ev_ready = 0;
    cfg(2, 2, 1);
    for (int t = 1; t <= 5; t++) begin
      tick();
      step(); step();
      if (t == 2) begin
        chk("t3_valid", {31'd0, ev_valid}, 32'd1);
        chk("t3_ch", {29'd0, ev_ch}, 32'd2);
      end
      if (t == 3) chk("t3_no_overrun", {27'd0, overrun}, 32'd0);
      if (t == 4) chk("t3_overrun", {27'd0, overrun}, 32'h4);
      if (t == 5) begin
        chk("t3_valid_held", {31'd0, ev_valid}, 32'd1);
        chk("t3_ch_held", {29'd0, ev_ch}, 32'd2);
      end
    end
    sb.push_back(2);
    ev_ready = 1;
    wait_idle("t3_drain");
    repeat (4) step();
    chk("t3_single", {31'd0, ev_valid}, 32'd0);
    chk("t3_sticky", {27'd0, overrun}, 32'h4);
    cfg(2, 0, 0);
    chk("t3_cfg_clears", {27'd0, overrun}, 32'd0);

    // 4: config write colliding with the expiring tick on ch1
    do_reset();
    cfg(1, 2, 1);
    tick();
    step();
    tick_in = 1; cfg_we = 1; cfg_ch = 1; cfg_period = 4; cfg_en = 1;
    step();
    tick_in = 0; cfg_we = 0;
    for (int t = 1; t <= 3; t++) begin
      tick();
      step(); step();
    end
    chk("t4_no_early", {31'd0, ev_valid}, 32'd0);
    sb.push_back(1);
    tick();
    wait_idle("t4_event");
    chk("t4_overrun", {27'd0, overrun}, 32'd0);

    // 5: period 0 on ch3 and out-of-range writes
    do_reset();
    cfg(0, 3, 1);
    cfg(3, 0, 1);
    cfg(5, 1, 1);
    cfg(7, 1, 1);
    for (int t = 1; t <= 6; t++) begin
      if (t % 3 == 0) sb.push_back(0);
      tick();
      step(); step(); step();
    end
    wait_idle("t5_drain");
    chk("t5_overrun", {27'd0, overrun}, 32'd0);

    // 6: reset while an offer is outstanding
    do_reset();
    ev_ready = 0;
    cfg(1, 1, 1);
    cfg(0, 1, 1);
    tick();
    tick();
    step();
    chk("t6_valid", {31'd0, ev_valid}, 32'd1);
    chk("t6_overrun", {27'd0, overrun}, 32'h3);
    do_reset();
    chk("t6_valid_dropped", {31'd0, ev_valid}, 32'd0);
    chk("t6_overrun_clr", {27'd0, overrun}, 32'd0);
    cfg(1, 1, 1);
    cfg(0, 1, 1);
    sb.push_back(0);
    sb.push_back(1);
    ev_ready = 1;
    tick();
    wait_idle("t6_restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
